// File: rtl/boot_sequencer_if.sv
// Valid/ready word stream feeding the boot sequencer.
// Master drives words; slave answers with ready.
interface boot_sequencer_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/boot_sequencer.sv
// Boot loader: streams a length-prefixed image into imem, then releases the core.
// Optional trailing checksum word enabled by defining BOOT_CHECKSUM_EN.
module boot_sequencer #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    boot_sequencer_if.slave in_s,
    input  logic            boot_start,
    output logic            imem_we,
    output logic [31:0]     imem_addr,
    output logic [31:0]     imem_wdata,
    output logic            core_reset,
    output logic            done,
    output logic            error
);
    localparam int IW = $clog2(DEPTH_WORDS) + 1;

    typedef enum logic [2:0] {
        S_LEN,
        S_LOAD,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM,
`endif
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [IW-1:0] len_q;
    logic [IW-1:0] idx_q;
    logic          accept;
    logic          len_ok;
    logic          last_word;
    logic          ready_n;
    logic          load_acc;

    assign accept    = in_s.in_valid && in_s.in_ready;
    assign len_ok    = (in_s.in_data != 32'd0) &&
                       (in_s.in_data <= 32'(DEPTH_WORDS));
    assign last_word = (idx_q + IW'(1)) == len_q;
    assign load_acc  = (state == S_LOAD) && accept;

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum_q;
    logic        csum_ok;

    assign csum_ok = (sum_q + in_s.in_data) == 32'd0;

    // Running image sum, restarted by each accepted length word
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if ((state == S_LEN) && accept) begin
            sum_q <= '0;
        end else if (load_acc) begin
            sum_q <= sum_q + in_s.in_data;
        end
    end
`endif

    // Next-state decode; in_ready follows the state being entered
    always_comb begin
        state_n = state;
        ready_n = 1'b0;
        case (state)
            S_LEN: begin
                if (accept) state_n = len_ok ? S_LOAD : S_ERROR;
            end
            S_LOAD: begin
`ifdef BOOT_CHECKSUM_EN
                if (accept && last_word) state_n = S_CSUM;
`else
                if (accept && last_word) state_n = S_FLUSH;
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_n = csum_ok ? S_FLUSH : S_ERROR;
            end
`endif
            S_FLUSH: state_n = S_DONE;
            S_DONE: begin
                if (boot_start) state_n = S_LEN;
            end
            S_ERROR: state_n = S_ERROR;
            default: state_n = S_LEN;
        endcase
        unique case (state_n)
`ifdef BOOT_CHECKSUM_EN
            S_LEN, S_LOAD, S_CSUM: ready_n = 1'b1;
`else
            S_LEN, S_LOAD: ready_n = 1'b1;
`endif
            default: ready_n = 1'b0;
        endcase
    end

    // State and registered outputs; release waits one full cycle in S_DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_LEN;
            in_s.in_ready <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            core_reset    <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            in_s.in_ready <= ready_n;
            imem_we       <= load_acc;
            if (load_acc) begin
                imem_addr  <= BASE_ADDR + (32'(idx_q) << 2);
                imem_wdata <= in_s.in_data;
            end
            core_reset <= !((state == S_DONE) && (state_n == S_DONE));
            done       <= (state == S_DONE) && (state_n == S_DONE);
            error      <= state_n == S_ERROR;
        end
    end

    // Image length and word index
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= '0;
            idx_q <= '0;
        end else if ((state == S_LEN) && accept) begin
            len_q <= in_s.in_data[IW-1:0];
            idx_q <= '0;
        end else if (load_acc) begin
            idx_q <= idx_q + IW'(1);
        end
    end
endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer with a queue-based image model.
// Honours BOOT_CHECKSUM_EN to exercise the trailing checksum word.
module tb_boot_sequencer;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        boot_start = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic [31:0] img[$];
    int          acc_e[$];

    boot_sequencer_if bus();

    boot_sequencer #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_s      (bus),
        .boot_start(boot_start),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write with the edge count that launched it
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            wc_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        boot_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, output int e);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = w;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout got ready=%b exp ready=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        e = cyc;
    endtask

    task automatic run_load(input int L, input int glo, input int ghi,
                            input bit bad, input bit flush_bs);
        int          e;
        int          g;
        logic [31:0] s;
        bit          exp_err;
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        acc_e.delete();
        exp_err = CSUM && bad;
        send_word(32'(L), e);
        s = '0;
        for (int i = 0; i < L; i++) begin
            g = (i == 0) ? 0 : int'($urandom_range(ghi, glo));
            if (g > 0) begin
                bus.in_valid = 1'b0;
                bus.in_data = $urandom;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (bus.in_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL stall_ready got=%b exp=1", bus.in_ready);
                    end
                end
            end
            send_word(img[i], e);
            acc_e.push_back(e);
            s += img[i];
        end
`ifdef BOOT_CHECKSUM_EN
        send_word(exp_err ? (32'd1 - s) : (32'd0 - s), e);
`endif
        bus.in_valid = 1'b0;
        if (flush_bs) boot_start = 1'b1;
        checks++;
        if ({bus.in_ready, error, done} !== {1'b0, exp_err, 1'b0}) begin
            failures++;
            $display("FAIL end_accept got rdy/err/done=%b%b%b exp=0%b0",
                     bus.in_ready, error, done, exp_err);
        end
        @(posedge clk);
        #1;
        boot_start = 1'b0;
        checks++;
        if ({core_reset, done, error} !== {1'b1, 1'b0, exp_err}) begin
            failures++;
            $display("FAIL flush_cycle got crst/done/err=%b%b%b exp=10%b",
                     core_reset, done, error, exp_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({core_reset, done, error, bus.in_ready} !==
            {exp_err, !exp_err, exp_err, 1'b0}) begin
            failures++;
            $display("FAIL release got crst/done/err/rdy=%b%b%b%b err_exp=%b",
                     core_reset, done, error, bus.in_ready, exp_err);
        end
        checks++;
        if (wa_q.size() != L) begin
            failures++;
            $display("FAIL write_count got=%0d exp=%0d", wa_q.size(), L);
        end
        for (int i = 0; i < L && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== BASE + 32'(4 * i) || wd_q[i] !== img[i] ||
                wc_q[i] != acc_e[i]) begin
                failures++;
                $display("FAIL write[%0d] got a=%h d=%h t=%0d exp a=%h d=%h t=%0d",
                         i, wa_q[i], wd_q[i], wc_q[i],
                         BASE + 32'(4 * i), img[i], acc_e[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, imem_we, core_reset, done, error} !== 5'b00100 ||
            imem_addr !== 32'd0 || imem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_vals got rdy/we/crst/done/err=%b%b%b%b%b a=%h d=%h exp 00100 0 0",
                     bus.in_ready, imem_we, core_reset, done, error,
                     imem_addr, imem_wdata);
        end
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, core_reset, done} !== 3'b110) begin
            failures++;
            $display("FAIL ready_after_reset got rdy/crst/done=%b%b%b exp=110",
                     bus.in_ready, core_reset, done);
        end
    endtask

    task automatic test_basic();
        do_reset();
        img = '{32'h00500093, 32'h00300113, 32'h002081B3};
        run_load(3, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_reset();
        img = '{$urandom, $urandom};
        run_load(2, 2, 2, 1'b0, 1'b0);
    endtask

    task automatic test_illegal_len();
        logic [31:0] bad_l[3];
        int          e;
        bad_l[0] = 32'd0;
        bad_l[1] = 32'(DEPTH + 1);
        bad_l[2] = $urandom | 32'h0000_0100;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            send_word(bad_l[k], e);
            bus.in_valid = 1'b0;
            checks++;
            if ({bus.in_ready, error, core_reset} !== 3'b011) begin
                failures++;
                $display("FAIL illegal_len L=%h got rdy/err/crst=%b%b%b exp=011",
                         bad_l[k], bus.in_ready, error, core_reset);
            end
            boot_start = 1'b1;
            @(posedge clk);
            #1;
            boot_start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if ({bus.in_ready, error, core_reset, done} !== 4'b0110) begin
                failures++;
                $display("FAIL error_sticky got rdy/err/crst/done=%b%b%b%b exp=0110",
                         bus.in_ready, error, core_reset, done);
            end
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        img = '{32'h1, 32'h2};
        run_load(2, 0, 0, 1'b0, 1'b0);
        do_reset();
        run_load(2, 0, 0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_reload();
        do_reset();
        img = '{$urandom, $urandom, $urandom, $urandom};
        run_load(4, 0, 1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        boot_start = 1'b1;
        @(posedge clk);
        #1;
        boot_start = 1'b0;
        checks++;
        if ({core_reset, done, bus.in_ready} !== 3'b101) begin
            failures++;
            $display("FAIL reload_rearm got crst/done/rdy=%b%b%b exp=101",
                     core_reset, done, bus.in_ready);
        end
        img = '{$urandom};
        run_load(1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midload();
        int e;
        do_reset();
        img = '{$urandom, $urandom, $urandom, $urandom, $urandom};
        send_word(32'd5, e);
        send_word(img[0], e);
        send_word(img[1], e);
        bus.in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== BASE + 32'd4) begin
            failures++;
            $display("FAIL midload_write got we=%b a=%h exp we=1 a=%h",
                     imem_we, imem_addr, BASE + 32'd4);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, imem_we, core_reset, done, error} !== 5'b00100 ||
            imem_addr !== 32'd0 || imem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL midload_reset got rdy/we/crst/done/err=%b%b%b%b%b a=%h d=%h exp 00100 0 0",
                     bus.in_ready, imem_we, core_reset, done, error,
                     imem_addr, imem_wdata);
        end
        reset = 1'b0;
        img = '{$urandom};
        run_load(1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
        run_load(DEPTH, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int L;
        bit bad;
        repeat (8) begin
            do_reset();
            L = ($urandom_range(3, 0) == 0) ? DEPTH : int'($urandom_range(DEPTH, 1));
            img.delete();
            for (int i = 0; i < L; i++) img.push_back($urandom);
            bad = CSUM && ($urandom_range(1, 0) == 1);
            run_load(L, 0, 2, bad, $urandom_range(1, 0) == 1);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        test_reset();
        test_basic();
        test_stall();
        test_illegal_len();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_reload();
        test_reset_midload();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
